snes_csync_gen: RTL

SNES_CSYNC_GEN -- requirements
Module: snes_csync_gen

---
 rtl/snes_csync_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/snes_csync_gen.sv
// SNES-style composite/horizontal/vertical sync generator driven by MCLK.
// Counts 1364 MCLK per line, 262/312 lines per field (+1 on odd interlaced fields).
module snes_csync_gen #(
    parameter int unsigned NTSC_LINES = 262,
    parameter int unsigned PAL_LINES  = 312
) (
    input  logic        MCLK_i,
    input  logic        RESET_i,
    input  logic        PALMODE,
    input  logic        INTERLACE_i,
    output logic        CSYNC_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic        FIELD_o,
    output logic        LINE_START_o,
    output logic        FRAME_START_o,
    output logic [10:0] HCNT_o,
    output logic [8:0]  VCNT_o
);

    localparam logic [10:0] H_LAST       = 11'd1363;
    localparam logic [10:0] H_SYNC_END   = 11'd100;
    localparam logic [10:0] EQ_END       = 11'd50;
    localparam logic [10:0] BROAD_END    = 11'd582;
    localparam logic [10:0] HALF_LINE    = 11'd682;
    localparam logic [10:0] EQ2_END      = 11'd732;
    localparam logic [10:0] BROAD2_END   = 11'd1264;
    localparam logic [8:0]  NTSC_LAST    = 9'(NTSC_LINES - 1);
    localparam logic [8:0]  PAL_LAST     = 9'(PAL_LINES - 1);
    localparam logic [8:0]  V_EQ_PRE_END = 9'd2;
    localparam logic [8:0]  V_BROAD_END  = 9'd5;
    localparam logic [8:0]  V_EQ_POST_END = 9'd8;

    typedef enum logic [1:0] {
        EQ_PRE,
        BROAD,
        EQ_POST,
        ACTIVE
    } line_t;

    line_t       state_q, state_d;
    logic [10:0] h_q, h_d;
    logic [8:0]  v_q, v_d;
    logic        field_q, field_d;
    logic        pal_q, pal_d;
    logic        il_q, il_d;
    logic        first_q, first_d;

    logic        csync_q, csync_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        field_out_q, field_out_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [8:0]  vcnt_q, vcnt_d;

    logic [8:0]  last_v;
    logic        h_wrap;
    logic        field_end;
    logic        out_of_range;
    logic        in_hsync;

    // Field length comes only from the latched mode, never from the live pins.
    always_comb begin
        last_v       = pal_q ? PAL_LAST : NTSC_LAST;
        last_v       = last_v + {8'd0, il_q & field_q};
        h_wrap       = (h_q == H_LAST);
        field_end    = h_wrap && (v_q == last_v);
        out_of_range = (h_q > H_LAST) || (v_q > last_v);
    end

    always_comb begin
        h_d     = h_q + 11'd1;
        v_d     = v_q;
        state_d = state_q;
        field_d = field_q;
        pal_d   = pal_q;
        il_d    = il_q;
        first_d = 1'b0;

        // The first clock after reset adopts the pins as the starting mode.
        if (first_q) begin
            pal_d = PALMODE;
            il_d  = INTERLACE_i;
        end

        if (out_of_range) begin
            h_d     = '0;
            v_d     = '0;
            state_d = EQ_PRE;
        end else if (h_wrap) begin
            h_d = '0;
            if (field_end) begin
                v_d     = '0;
                state_d = EQ_PRE;
                pal_d   = PALMODE;
                il_d    = INTERLACE_i;
                field_d = INTERLACE_i ? ~field_q : 1'b0;
            end else begin
                v_d = v_q + 9'd1;
                case (state_q)
                    EQ_PRE:  if (v_q == V_EQ_PRE_END)  state_d = BROAD;
                    BROAD:   if (v_q == V_BROAD_END)   state_d = EQ_POST;
                    EQ_POST: if (v_q == V_EQ_POST_END) state_d = ACTIVE;
                    ACTIVE:  state_d = ACTIVE;
                    default: state_d = EQ_PRE;
                endcase
            end
        end
    end

    always_comb begin
        in_hsync = (h_q < H_SYNC_END);
        hsync_d  = ~in_hsync;
        vsync_d  = (state_q != BROAD);
        case (state_q)
            ACTIVE:          csync_d = ~in_hsync;
            EQ_PRE, EQ_POST: csync_d = ~((h_q < EQ_END) ||
                                         ((h_q >= HALF_LINE) && (h_q < EQ2_END)));
            BROAD:           csync_d = ~((h_q < BROAD_END) ||
                                         ((h_q >= HALF_LINE) && (h_q < BROAD2_END)));
            default:         csync_d = 1'b1;
        endcase
        field_out_d   = field_q;
        line_start_d  = (h_q == '0);
        frame_start_d = (h_q == '0) && (v_q == '0);
        hcnt_d        = h_q;
        vcnt_d        = v_q;
    end

    always_ff @(posedge MCLK_i or posedge RESET_i) begin
        if (RESET_i) begin
            h_q           <= '0;
            v_q           <= '0;
            state_q       <= EQ_PRE;
            field_q       <= 1'b0;
            pal_q         <= 1'b0;
            il_q          <= 1'b0;
            first_q       <= 1'b1;
            csync_q       <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            field_out_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            state_q       <= state_d;
            field_q       <= field_d;
            pal_q         <= pal_d;
            il_q          <= il_d;
            first_q       <= first_d;
            csync_q       <= csync_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            field_out_q   <= field_out_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
        end
    end

    assign CSYNC_o       = csync_q;
    assign HSYNC_o       = hsync_q;
    assign VSYNC_o       = vsync_q;
    assign FIELD_o       = field_out_q;
    assign LINE_START_o  = line_start_q;
    assign FRAME_START_o = frame_start_q;
    assign HCNT_o        = hcnt_q;
    assign VCNT_o        = vcnt_q;

endmodule
